// File: rtl/digit_serial_alu.sv
// Digit-serial ALU: latches two operands and an opcode, then walks them
// LSB first, DIGIT bits per clock, through a single registered carry/flag.
// The finished result, final carry/flag and a zero flag are offered over
// a valid/ready handshake.
module digit_serial_alu #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  // A digit size that does not tile the operand would leave a ragged last digit.
  if ((WIDTH % DIGIT) != 0) begin : gBadDigit
    $error("digit_serial_alu: DIGIT (%0d) must divide WIDTH (%0d)", DIGIT, WIDTH);
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  opA_q, opA_d;
  logic [WIDTH-1:0]  opB_q, opB_d;
  logic [WIDTH-1:0]  res_q, res_d;
  logic [2:0]        op_q, op_d;
  logic              carry_q, carry_d;
  logic              zero_q, zero_d;
  logic [CW-1:0]     cnt_q, cnt_d;

  logic [DIGIT-1:0]       digitRes;
  logic                   digitCarry;
  logic                   bitA, bitB, bitR, rip;
  logic [WIDTH+DIGIT-1:0] resShift;

  // Apply the opcode's bit rule across the low digit, rippling the carry bit to bit.
  always_comb begin
    digitRes = '0;
    rip      = carry_q;
    bitA     = 1'b0;
    bitB     = 1'b0;
    bitR     = 1'b0;
    for (int i = 0; i < DIGIT; i++) begin
      bitA = opA_q[i];
      bitB = opB_q[i];
      case (op_q)
        3'b000: begin bitR = bitA; end
        3'b001: begin bitR = bitA | bitB; rip = rip | bitA | bitB; end
        3'b010: begin
          bitR = bitA ^ bitB ^ rip;
          rip  = (bitA & bitB) | (rip & (bitA ^ bitB));
        end
        3'b011: begin
          bitR = bitA ^ bitB ^ rip;
          rip  = (~bitA & bitB) | (~(bitA ^ bitB) & rip);
        end
        3'b100: begin bitR = bitA & ~bitB;    rip = rip & bitA & ~bitB; end
        3'b101: begin bitR = ~(bitA ^ bitB);  rip = rip & ~(bitA ^ bitB); end
        3'b110: begin bitR = bitA & bitB;     rip = rip & bitA & bitB; end
        default: begin bitR = bitA ^ bitB;    rip = rip & (bitA ^ bitB); end
      endcase
      digitRes[i] = bitR;
    end
    digitCarry = rip;
  end

  // Sequencing: accept in IDLE, shift one digit per RUN cycle, hold results in DONE.
  always_comb begin
    state_d  = state_q;
    opA_d    = opA_q;
    opB_d    = opB_q;
    res_d    = res_q;
    op_d     = op_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    cnt_d    = cnt_q;
    resShift = {digitRes, res_q};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          opA_d   = a;
          opB_d   = b;
          op_d    = s;
          carry_d = s[2];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        res_d   = resShift[WIDTH+DIGIT-1:DIGIT];
        opA_d   = opA_q >> DIGIT;
        opB_d   = opB_q >> DIGIT;
        carry_d = digitCarry;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          zero_d  = (res_d == '0);
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset wins over everything, discarding any operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      opA_q   <= '0;
      opB_q   <= '0;
      res_q   <= '0;
      op_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      res_q   <= res_d;
      op_q    <= op_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out       = res_q;
  assign cout      = carry_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_digit_serial_alu.sv
// Directed and random checks of digit_serial_alu at WIDTH=8 for DIGIT=2, 1 and 8.
module tb_digit_serial_alu;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] inValid, outReady, inReady, outValid, coutW, zeroW;
  logic [W-1:0] a, b;
  logic [2:0] s;
  logic [W-1:0] outW [3];
  int latency [3] = '{4, 8, 1};
  int total = 0;
  int bad = 0;

  // Free-running clock shared by all three instances.
  always #5 clk = ~clk;

  digit_serial_alu #(.WIDTH(W), .DIGIT(2)) dut2 (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(a), .b(b), .s(s), .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out(outW[0]), .cout(coutW[0]), .zero(zeroW[0]));

  digit_serial_alu #(.WIDTH(W), .DIGIT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(a), .b(b), .s(s), .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out(outW[1]), .cout(coutW[1]), .zero(zeroW[1]));

  digit_serial_alu #(.WIDTH(W), .DIGIT(8)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid[2]), .in_ready(inReady[2]),
    .a(a), .b(b), .s(s), .out_valid(outValid[2]), .out_ready(outReady[2]),
    .out(outW[2]), .cout(coutW[2]), .zero(zeroW[2]));

  // Full-width reference: returns {cout, out}.
  function automatic logic [8:0] refAlu(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] r;
    logic c;
    case (op)
      3'b000: begin r = x;          c = 1'b0; end
      3'b001: begin r = x | y;      c = |r; end
      3'b010: begin {c, r} = {1'b0, x} + {1'b0, y}; end
      3'b011: begin r = x - y;      c = (x < y); end
      3'b100: begin r = x & ~y;     c = &r; end
      3'b101: begin r = ~(x ^ y);   c = (x == y); end
      3'b110: begin r = x & y;      c = &r; end
      default: begin r = x ^ y;     c = &r; end
    endcase
    return {c, r};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  // Offers one operation to instance k (called at a negedge), waits for the
  // result, checks it, optionally stalls out_ready for hold cycles, then retires it.
  task automatic applyStimulus(input int k, input logic [2:0] op, input logic [7:0] av,
                               input logic [7:0] bv, input logic [7:0] expOut,
                               input logic expCout, input int hold, input string tag);
    int cycles;
    logic rdyLow;
    checkOutput({tag, ".inready"}, inReady[k], 1);
    a = av; b = bv; s = op; inValid[k] = 1'b1;
    @(negedge clk);
    inValid[k] = 1'b0;
    a = ~av; b = ~bv; s = ~op;
    cycles = 0;
    rdyLow = 1'b1;
    while (!outValid[k] && cycles < 40) begin
      if (inReady[k]) rdyLow = 1'b0;
      @(negedge clk);
      cycles++;
    end
    if (inReady[k]) rdyLow = 1'b0;
    checkOutput({tag, ".latency"}, cycles, latency[k]);
    checkOutput({tag, ".busy"}, rdyLow, 1);
    checkOutput({tag, ".out"}, outW[k], expOut);
    checkOutput({tag, ".cout"}, coutW[k], expCout);
    checkOutput({tag, ".zero"}, zeroW[k], (expOut == 8'h00));
    for (int h = 0; h < hold; h++) begin
      inValid[k] = 1'b1;
      @(negedge clk);
      checkOutput({tag, ".holdValid"}, outValid[k], 1);
      checkOutput({tag, ".holdReady"}, inReady[k], 0);
      checkOutput({tag, ".holdOut"}, outW[k], expOut);
      checkOutput({tag, ".holdCout"}, coutW[k], expCout);
      checkOutput({tag, ".holdZero"}, zeroW[k], (expOut == 8'h00));
    end
    inValid[k] = 1'b0;
    outReady[k] = 1'b1;
    @(negedge clk);
    outReady[k] = 1'b0;
    checkOutput({tag, ".retireReady"}, inReady[k], 1);
    checkOutput({tag, ".retireValid"}, outValid[k], 0);
  endtask

  // Watchdog so a stuck design still produces a verdict.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [8:0] r;
    logic [2:0] op;
    logic [7:0] av, bv;
    rst = 1'b1; inValid = '0; outReady = '0; a = '0; b = '0; s = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("reset%0d.inready", k), inReady[k], 1);
      checkOutput($sformatf("reset%0d.outvalid", k), outValid[k], 0);
      checkOutput($sformatf("reset%0d.out", k), outW[k], 0);
      checkOutput($sformatf("reset%0d.cout", k), coutW[k], 0);
      checkOutput($sformatf("reset%0d.zero", k), zeroW[k], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    applyStimulus(0, 3'b010, 8'hFF, 8'h01, 8'h00, 1'b1, 0, "addWrap");
    applyStimulus(0, 3'b011, 8'h03, 8'h05, 8'hFE, 1'b1, 0, "subBorrow");
    applyStimulus(0, 3'b011, 8'h05, 8'h03, 8'h02, 1'b0, 0, "subNoBorrow");
    applyStimulus(0, 3'b101, 8'h5A, 8'h5A, 8'hFF, 1'b1, 0, "xnorEq");
    applyStimulus(0, 3'b101, 8'h5A, 8'h5B, 8'hFE, 1'b0, 0, "xnorNe");
    applyStimulus(0, 3'b110, 8'hFF, 8'hFF, 8'hFF, 1'b1, 0, "andOnes");
    applyStimulus(0, 3'b110, 8'hF0, 8'hFF, 8'hF0, 1'b0, 0, "andPart");
    applyStimulus(0, 3'b001, 8'h00, 8'h00, 8'h00, 1'b0, 0, "orZero");
    applyStimulus(0, 3'b100, 8'hF3, 8'h0C, 8'hF3, 1'b0, 0, "andn");
    applyStimulus(0, 3'b111, 8'hA5, 8'h5A, 8'hFF, 1'b1, 0, "xorAllDiff");
    applyStimulus(0, 3'b000, 8'h9C, 8'h33, 8'h9C, 1'b0, 3, "passHold");
    applyStimulus(0, 3'b010, 8'h40, 8'h41, 8'h81, 1'b0, 0, "addAfterHold");

    // Reset during the second RUN cycle discards the operation.
    a = 8'h77; b = 8'h11; s = 3'b010; inValid[0] = 1'b1;
    @(negedge clk);
    inValid[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midReset.inready", inReady[0], 1);
    checkOutput("midReset.outvalid", outValid[0], 0);
    checkOutput("midReset.out", outW[0], 0);
    checkOutput("midReset.cout", coutW[0], 0);
    checkOutput("midReset.zero", zeroW[0], 0);
    applyStimulus(0, 3'b010, 8'h10, 8'h22, 8'h32, 1'b0, 0, "addAfterReset");

    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        op = 3'($urandom_range(0, 7));
        av = 8'($urandom);
        bv = 8'($urandom);
        r = refAlu(op, av, bv);
        applyStimulus(k, op, av, bv, r[7:0], r[8], i % 3, $sformatf("rnd%0d_%0d", k, i));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
